instr_prefetch_queue: RTL and testbench
=======================================

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 SHALL be clocked by one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_WIDTH, 32, instruction and PC width in bits.
REQ-003 Parameter DEPTH, 4, number of queue entries (power of two, 2..16).
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port in_valid  input  1  upstream fetch offers an instruction.
REQ-007 Port in_ready  output  1  queue accepts the offered instruction this cycle.
REQ-008 Port in_instr  input  DATA_WIDTH  fetched instruction word.
REQ-009 Port in_pc  input  DATA_WIDTH  PC of in_instr.
REQ-010 Port out_valid  output  1  head entry is presented to the core.
REQ-011 Port out_ready  input  1  core consumes the head entry this cycle.
REQ-012 Port out_instr  output  DATA_WIDTH  head instruction word.
REQ-013 Port out_pc  output  DATA_WIDTH  head PC.
REQ-014 Port flush  input  1  core redirect (taken beq or jal); discard all entries.
REQ-015 Port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 Port drop_cnt  output  8  saturating count of entries discarded by flush.
REQ-017 Port out_is_ctrl  output  1  head opcode is beq (1100011) or jal (1101111).
REQ-018 Port out_illegal  output  1  head opcode is not addi, add, beq or jal.

Function
REQ-019 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-020 in_ready SHALL equal (count < DEPTH); no combinational path from out_ready to in_ready.
REQ-021 A pushed entry SHALL appear at the head no earlier than the next cycle (1-cycle latency, no bypass).
REQ-022 out_valid SHALL equal (count != 0); out_instr/out_pc SHALL come from the head register and hold stable while out_valid && !out_ready.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 flush SHALL override push and pop: next cycle count=0, out_valid=0, pointers reset; the input offered during flush is dropped.
REQ-026 On flush, drop_cnt SHALL increase by the count value at that cycle, saturating at 255; flush with count=0 leaves it unchanged.
REQ-027 out_instr/out_pc SHALL read as 0 when out_valid=0.
REQ-028 Predecode flags SHALL be derived from out_instr[6:0] and SHALL be 0 when out_valid=0.

Reset
REQ-029 rst SHALL set count=0, out_valid=0, in_ready=1, drop_cnt=0, out_instr=0, out_pc=0, out_is_ctrl=0, out_illegal=0, and both pointers to 0.
REQ-030 rst asserted mid-operation SHALL discard all entries without updating drop_cnt; rst has priority over flush.
REQ-031 Storage array contents need not be reset.

Configuration
REQ-032 Macro PREFETCH_PREDECODE_EN SHALL compile in the opcode predecoder driving out_is_ctrl and out_illegal per REQ-017/018/028.
REQ-033 Without PREFETCH_PREDECODE_EN, out_is_ctrl and out_illegal SHALL be tied to 0 and no predecode logic SHALL be instantiated; all other behaviour is unchanged.

Verification
REQ-034 Reset, then push 0x00500093 (addi) at pc 0x0 with out_ready=0 -> next cycle out_valid=1, out_instr=0x00500093, count=1, out_is_ctrl=0, out_illegal=0.
REQ-035 Push 4 words with out_ready=0 -> count=4, in_ready=0; 5th word is held off; then pop 4 -> words emerge in order, count=0, out_valid=0.
REQ-036 With count=2, push and pop in the same cycle -> count stays 2, order preserved; repeat 10 times to cover pointer wrap.
REQ-037 With count=3, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, drop_cnt=3, pushed word is absent.
REQ-038 Present 0x0000006F (jal) then 0xFFFFFFFF -> out_is_ctrl=1 then out_illegal=1 with macro; both 0 without macro.
REQ-039 Issue 100 flushes each with count=4 -> drop_cnt saturates at 255; rst -> drop_cnt=0.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch FIFO between fetch and decode, with flush, drop counter and
// an optional opcode predecoder compiled in by PREFETCH_PREDECODE_EN.
module instr_prefetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_instr,
    input  logic [DATA_WIDTH-1:0]        in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_instr,
    output logic [DATA_WIDTH-1:0]        out_pc,
    input  logic                         flush,
    output logic [$clog2(DEPTH):0]       count,
    output logic [7:0]                   drop_cnt,
    output logic                         out_is_ctrl,
    output logic                         out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [7:0]            drop_q;
    logic                  push;
    logic                  pop;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [CNT_W-1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + 9'(b);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (count_q < FULL_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;
    assign drop_cnt  = drop_q;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= sat_add8(drop_q, count_q);
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef PREFETCH_PREDECODE_EN
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [6:0] opcode;
    assign opcode      = out_instr[6:0];
    assign out_is_ctrl = out_valid && ((opcode == OP_BEQ) || (opcode == OP_JAL));
    assign out_illegal = out_valid && !((opcode == OP_ADDI) || (opcode == OP_ADD) ||
                                        (opcode == OP_BEQ)  || (opcode == OP_JAL));
`else
    assign out_is_ctrl = 1'b0;
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: a negedge monitor tracks an occupancy model and
// an expected-entry queue, while the stimulus thread runs directed vectors with fixed answers.
module tb_instr_prefetch_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_instr = '0;
    logic [DW-1:0] in_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [DW-1:0] out_pc;
    logic          flush = 1'b0;
    logic [2:0]    count;
    logic [7:0]    drop_cnt;
    logic          out_is_ctrl;
    logic          out_illegal;

    instr_prefetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .flush(flush), .count(count), .drop_cnt(drop_cnt),
        .out_is_ctrl(out_is_ctrl), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
    } ent_t;

    ent_t exp_q[$];
    int   m_count = 0;
    int   m_drop  = 0;
    bit   started = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

`ifdef PREFETCH_PREDECODE_EN
    localparam bit PD_EN = 1'b1;
`else
    localparam bit PD_EN = 1'b0;
`endif

    function automatic logic exp_ctrl(input logic [DW-1:0] w);
        logic [6:0] op;
        op = w[6:0];
        return PD_EN && (op == 7'h63 || op == 7'h6F);
    endfunction

    function automatic logic exp_ill(input logic [DW-1:0] w);
        logic [6:0] op;
        op = w[6:0];
        return PD_EN && !(op == 7'h13 || op == 7'h33 || op == 7'h63 || op == 7'h6F);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    endtask

    // Monitor: compare DUT against the model, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        if (started) begin
            chk("mon_count", 32'(count), 32'(m_count));
            chk("mon_out_valid", 32'(out_valid), 32'(m_count != 0));
            chk("mon_in_ready", 32'(in_ready), 32'(m_count < DEPTH));
            chk("mon_drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (m_count != 0) begin
                chk("mon_head_instr", out_instr, exp_q[0].instr);
                chk("mon_head_pc", out_pc, exp_q[0].pc);
                chk("mon_is_ctrl", 32'(out_is_ctrl), 32'(exp_ctrl(exp_q[0].instr)));
                chk("mon_illegal", 32'(out_illegal), 32'(exp_ill(exp_q[0].instr)));
            end else begin
                chk("mon_idle_instr", out_instr, '0);
                chk("mon_idle_pc", out_pc, '0);
                chk("mon_idle_flags", {30'd0, out_is_ctrl, out_illegal}, '0);
            end
        end
        if (rst) begin
            exp_q.delete();
            m_count = 0;
            m_drop  = 0;
            started = 1'b1;
        end else if (started) begin
            if (flush) begin
                m_drop = (m_drop + m_count > 255) ? 255 : m_drop + m_count;
                exp_q.delete();
                m_count = 0;
            end else begin
                bit do_pop, do_push;
                do_pop  = out_ready && (m_count != 0);
                do_push = in_valid && (m_count < DEPTH);
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) exp_q.push_back('{instr: in_instr, pc: in_pc});
                m_count = m_count + int'(do_push) - int'(do_pop);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic v, input logic [DW-1:0] w, input logic [DW-1:0] p);
        in_valid = v;
        in_instr = w;
        in_pc    = p;
    endtask

    logic [DW-1:0] words [4];

    initial begin
        words[0] = 32'h0010_0093;
        words[1] = 32'h0020_0113;
        words[2] = 32'h0031_01B3;
        words[3] = 32'h0041_8233;

        cyc(2);
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);

        // single addi, head visible one cycle after push
        offer(1'b1, 32'h0050_0093, 32'h0);
        chk("no_bypass", 32'(out_valid), 0);
        cyc();
        offer(1'b0, '0, '0);
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_instr", out_instr, 32'h0050_0093);
        chk("addi_count", 32'(count), 1);
        chk("addi_flags", {30'd0, out_is_ctrl, out_illegal}, 0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("addi_drained", 32'(count), 0);

        // fill to full, fifth word held off
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, words[i], 32'h10 + 32'(4 * i));
            cyc();
        end
        offer(1'b1, 32'hDEAD_0013, 32'h20);
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        cyc(2);
        chk("held_off_count", 32'(count), 4);
        offer(1'b0, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", out_instr, words[i]);
            cyc();
        end
        out_ready = 1'b0;
        chk("drain_count", 32'(count), 0);
        chk("drain_valid", 32'(out_valid), 0);

        // steady state at count=2 with simultaneous push/pop across pointer wrap
        offer(1'b1, 32'hA000_0013, 32'h40); cyc();
        offer(1'b1, 32'hB000_0013, 32'h44); cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(1'b1, 32'h0000_0033 | (32'(i) << 12), 32'h48 + 32'(4 * i));
            cyc();
            chk("pushpop_count", 32'(count), 2);
        end
        offer(1'b0, '0, '0);
        chk("pushpop_head", out_instr, 32'h0000_8033);
        chk("pushpop_head_pc", out_pc, 32'h68);
        cyc(2);
        out_ready = 1'b0;
        chk("pushpop_empty", 32'(count), 0);

        // flush with count=3 and a word on the input
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, words[i], 32'h80 + 32'(4 * i));
            cyc();
        end
        offer(1'b1, 32'hBAD0_0013, 32'h8C);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        offer(1'b0, '0, '0);
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_drop", 32'(drop_cnt), 3);
        cyc();
        chk("flush_word_absent", 32'(out_valid), 0);

        // predecode: jal then all-ones
        offer(1'b1, 32'h0000_006F, 32'h100); cyc();
        offer(1'b1, 32'hFFFF_FFFF, 32'h104); cyc();
        offer(1'b0, '0, '0);
        chk("jal_is_ctrl", 32'(out_is_ctrl), 32'(PD_EN));
        chk("jal_illegal", 32'(out_illegal), 0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("ones_instr", out_instr, 32'hFFFF_FFFF);
        chk("ones_is_ctrl", 32'(out_is_ctrl), 0);
        chk("ones_illegal", 32'(out_illegal), 32'(PD_EN));
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // 100 flushes of a full queue saturate the drop counter
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < 4; i++) begin
                offer(1'b1, words[i], 32'h200 + 32'(4 * i));
                cyc();
            end
            offer(1'b0, '0, '0);
            flush = 1'b1;
            cyc();
            flush = 1'b0;
            if (k == 0) chk("drop_after_one", 32'(drop_cnt), 7);
        end
        chk("drop_saturated", 32'(drop_cnt), 255);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("drop_after_rst", 32'(drop_cnt), 0);

        // reset beats a simultaneous flush and does not count drops
        offer(1'b1, words[0], 32'h300); cyc();
        offer(1'b1, words[1], 32'h304); cyc();
        offer(1'b0, '0, '0);
        chk("pre_rst_count", 32'(count), 2);
        rst = 1'b1;
        flush = 1'b1;
        cyc();
        rst = 1'b0;
        flush = 1'b0;
        chk("rst_flush_count", 32'(count), 0);
        chk("rst_flush_drop", 32'(drop_cnt), 0);
        chk("rst_flush_in_ready", 32'(in_ready), 1);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
